// File: rtl/mbist_pkg.sv
// rtl/mbist_pkg.sv - shared March element, logger state and entry-width definitions
package mbist_pkg;

  // March element encoding as issued by the controller on cmp_elem
  localparam logic [1:0] ELEM_W0        = 2'd0;
  localparam logic [1:0] ELEM_R0W1R1_UP = 2'd1;
  localparam logic [1:0] ELEM_R1W0R0_DN = 2'd2;
  localparam logic [1:0] ELEM_R0_FINAL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } log_state_e;

  // Log entry is {address, element, syndrome}
  function automatic int unsigned log_entry_w(input int unsigned cawidth,
                                              input int unsigned dwidth);
    return cawidth + 2 + dwidth;
  endfunction

endpackage

// File: rtl/mbist_fail_fifo.sv
// rtl/mbist_fail_fifo.sv - first-failures FIFO; pushes while full are dropped unless a pop frees a slot
module mbist_fail_fifo #(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && (!full || pop);
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  // Pointer and occupancy next state; pointers wrap naturally (DEPTH is a power of two)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers, cleared asynchronously so no partial entry survives reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents behind an empty count are never observed
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mbist_fail_logger.sv
// rtl/mbist_fail_logger.sv - MBIST compare checker with sticky verdict, saturating count and failure log
module mbist_fail_logger
  import mbist_pkg::*;
#(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned CAWIDTH   = 4,
  parameter int unsigned LOG_DEPTH = 4,
  parameter int unsigned CNTW      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               test_start,
  input  logic               test_done,
  input  logic               cmp_valid,
  input  logic [CAWIDTH-1:0] cmp_addr,
  input  logic [1:0]         cmp_elem,
  input  logic [DWIDTH-1:0]  cmp_exp,
  input  logic [DWIDTH-1:0]  cmp_act,
  output logic               log_valid,
  input  logic               log_ready,
  output logic [CAWIDTH-1:0] log_addr,
  output logic [1:0]         log_elem,
  output logic [DWIDTH-1:0]  log_syndrome,
  output logic [CNTW-1:0]    fail_count,
  output logic               fail,
  output logic               overflow,
  output logic               done
);

  localparam int unsigned EW = log_entry_w(CAWIDTH, DWIDTH);

  log_state_e          state_q, state_d;
  logic [CNTW-1:0]     fail_count_q, fail_count_d;
  logic                fail_q, fail_d;
  logic                overflow_q, overflow_d;
  logic                mismatch;
  logic                fifo_pop, fifo_full, fifo_empty;
  logic [EW-1:0]       push_entry, head_entry;

  // A compare only counts in RUN; a start in the same cycle wins over it
  assign mismatch   = (state_q == ST_RUN) && !test_start && cmp_valid && (cmp_exp != cmp_act);
  assign push_entry = {cmp_addr, cmp_elem, cmp_exp ^ cmp_act};
  assign fifo_pop   = log_valid && log_ready;

  mbist_fail_fifo #(
    .WIDTH(EW),
    .DEPTH(LOG_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (test_start),
    .push     (mismatch),
    .push_data(push_entry),
    .pop      (fifo_pop),
    .pop_data (head_entry),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // State transitions plus verdict/counter updates
  always_comb begin
    state_d      = state_q;
    fail_count_d = fail_count_q;
    fail_d       = fail_q;
    overflow_d   = overflow_q;
    if (test_start) begin
      state_d      = ST_RUN;
      fail_count_d = '0;
      fail_d       = 1'b0;
      overflow_d   = 1'b0;
    end else begin
      if (mismatch) begin
        fail_d = 1'b1;
        if (fail_count_q != {CNTW{1'b1}}) fail_count_d = fail_count_q + CNTW'(1);
        if (fifo_full && !fifo_pop) overflow_d = 1'b1;
      end
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN:  if (test_done) state_d = ST_DONE;
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and verdict registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      fail_count_q <= '0;
      fail_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fail_count_q <= fail_count_d;
      fail_q       <= fail_d;
      overflow_q   <= overflow_d;
    end
  end

  assign log_valid    = !fifo_empty;
  assign log_addr     = log_valid ? head_entry[EW-1 -: CAWIDTH]       : '0;
  assign log_elem     = log_valid ? head_entry[DWIDTH+1 -: 2]         : 2'b00;
  assign log_syndrome = log_valid ? head_entry[DWIDTH-1:0]            : '0;
  assign fail_count   = fail_count_q;
  assign fail         = fail_q;
  assign overflow     = overflow_q;
  assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_mbist_fail_logger.sv
// tb/tb_mbist_fail_logger.sv - directed-vector bench for mbist_fail_logger
module tb_mbist_fail_logger;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       test_start = 1'b0;
  logic       test_done = 1'b0;
  logic       cmp_valid = 1'b0;
  logic [3:0] cmp_addr = '0;
  logic [1:0] cmp_elem = '0;
  logic [7:0] cmp_exp = '0;
  logic [7:0] cmp_act = '0;
  logic       log_ready = 1'b0;
  logic       log_valid;
  logic [3:0] log_addr;
  logic [1:0] log_elem;
  logic [7:0] log_syndrome;
  logic [7:0] fail_count;
  logic       fail;
  logic       overflow;
  logic       done;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  mbist_fail_logger #(
    .DWIDTH(8), .CAWIDTH(4), .LOG_DEPTH(4), .CNTW(8)
  ) dut (
    .clk(clk), .rst(rst), .test_start(test_start), .test_done(test_done),
    .cmp_valid(cmp_valid), .cmp_addr(cmp_addr), .cmp_elem(cmp_elem),
    .cmp_exp(cmp_exp), .cmp_act(cmp_act),
    .log_valid(log_valid), .log_ready(log_ready), .log_addr(log_addr),
    .log_elem(log_elem), .log_syndrome(log_syndrome),
    .fail_count(fail_count), .fail(fail), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; inputs were set after the previous sample, pulses released after this one
  task automatic step();
    @(posedge clk);
    #1;
    test_start = 1'b0;
    test_done  = 1'b0;
    cmp_valid  = 1'b0;
    log_ready  = 1'b0;
  endtask

  task automatic do_cmp(input logic [3:0] a, input logic [1:0] e,
                        input logic [7:0] x, input logic [7:0] y);
    cmp_valid = 1'b1; cmp_addr = a; cmp_elem = e; cmp_exp = x; cmp_act = y;
    step();
  endtask

  task automatic do_start();
    test_start = 1'b1;
    step();
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, ".log_valid"}, log_valid, 0);
    check_eq({tag, ".log_addr"}, log_addr, 0);
    check_eq({tag, ".log_syn"}, log_syndrome, 0);
    check_eq({tag, ".count"}, fail_count, 0);
    check_eq({tag, ".fail"}, fail, 0);
    check_eq({tag, ".ovf"}, overflow, 0);
    check_eq({tag, ".done"}, done, 0);
  endtask

  initial begin
    #12;
    check_idle_outputs("reset");
    rst = 1'b1;
    #4;

    // Clean run
    do_start();
    for (int i = 0; i < 16; i++) do_cmp(i[3:0], 2'd1, 8'h00, 8'h00);
    test_done = 1'b1;
    step();
    check_eq("clean.fail", fail, 0);
    check_eq("clean.count", fail_count, 0);
    check_eq("clean.log_valid", log_valid, 0);
    check_eq("clean.done", done, 1);

    // Single fault
    do_start();
    check_eq("single.done_cleared", done, 0);
    do_cmp(4'd5, 2'd1, 8'hFF, 8'hF7);
    check_eq("single.fail", fail, 1);
    check_eq("single.count", fail_count, 1);
    check_eq("single.log_valid", log_valid, 1);
    check_eq("single.addr", log_addr, 5);
    check_eq("single.elem", log_elem, 1);
    check_eq("single.syn", log_syndrome, 8'h08);
    step();
    check_eq("single.hold_valid", log_valid, 1);
    log_ready = 1'b1;
    step();
    check_eq("single.popped", log_valid, 0);
    check_eq("single.zero_addr", log_addr, 0);

    // Overflow: 6 mismatches, first 4 kept in order
    do_start();
    for (int i = 0; i < 6; i++) do_cmp(i[3:0], i[1:0], 8'hFF, 8'hFF ^ (8'h01 << i));
    check_eq("ovf.count", fail_count, 6);
    check_eq("ovf.flag", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("ovf.valid%0d", i), log_valid, 1);
      check_eq($sformatf("ovf.addr%0d", i), log_addr, i);
      check_eq($sformatf("ovf.elem%0d", i), log_elem, i & 3);
      check_eq($sformatf("ovf.syn%0d", i), log_syndrome, 32'h1 << i);
      log_ready = 1'b1;
      step();
    end
    check_eq("ovf.drained", log_valid, 0);

    // Full log with simultaneous pop and push
    do_start();
    for (int i = 8; i < 12; i++) do_cmp(i[3:0], 2'd2, 8'h00, 8'h01);
    log_ready = 1'b1;
    do_cmp(4'd12, 2'd3, 8'h00, 8'h80);
    check_eq("pp.ovf", overflow, 0);
    check_eq("pp.count", fail_count, 5);
    for (int i = 9; i < 13; i++) begin
      check_eq($sformatf("pp.valid%0d", i), log_valid, 1);
      check_eq($sformatf("pp.addr%0d", i), log_addr, i);
      log_ready = 1'b1;
      step();
    end
    check_eq("pp.drained", log_valid, 0);

    // Saturation, then start wins over a same-cycle compare
    do_start();
    for (int i = 0; i < 300; i++) do_cmp(i[3:0], 2'd1, 8'h55, 8'hAA);
    check_eq("sat.count", fail_count, 255);
    check_eq("sat.ovf", overflow, 1);
    check_eq("sat.fail", fail, 1);
    test_start = 1'b1;
    do_cmp(4'd1, 2'd1, 8'h00, 8'hFF);
    check_idle_outputs("restart");
    // Done with a same-cycle compare: compare processed, then DONE
    test_done = 1'b1;
    do_cmp(4'd3, 2'd3, 8'h0F, 8'h0E);
    check_eq("donecmp.count", fail_count, 1);
    check_eq("donecmp.done", done, 1);
    check_eq("donecmp.syn", log_syndrome, 8'h01);
    do_cmp(4'd4, 2'd3, 8'h0F, 8'h00);
    check_eq("done_ignored.count", fail_count, 1);
    check_eq("done_ignored.done", done, 1);

    // Asynchronous reset mid-run with 2 logged entries
    do_start();
    do_cmp(4'd2, 2'd1, 8'h00, 8'h03);
    do_cmp(4'd7, 2'd2, 8'h00, 8'h30);
    check_eq("arst.pre_count", fail_count, 2);
    #2;
    rst = 1'b0;
    #1;
    check_idle_outputs("arst");
    #1;
    rst = 1'b1;
    step();
    do_cmp(4'd9, 2'd1, 8'h00, 8'hFF);
    check_eq("idle_ignored.count", fail_count, 0);
    check_eq("idle_ignored.valid", log_valid, 0);
    do_start();
    do_cmp(4'd9, 2'd1, 8'h00, 8'hFF);
    check_eq("after_arst.count", fail_count, 1);
    check_eq("after_arst.addr", log_addr, 9);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
